mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the CPU data bus, downstream of the core's data port; consumes data_addr/data_wdata/data_wenable and returns read data in the same cycle.
- Buffers bytes in a small TX FIFO and serialises them 8N1, LSB first, on a single output pin.
- Exposes status, sticky overflow and a baud divisor register, so firmware can poll without stalling the single-cycle core, which has no wait input.

---
 rtl/mmio_uart_tx_pkg.sv | 26 ++
 rtl/mmio_sync_fifo.sv | 59 +++++
 rtl/mmio_uart_tx.sv | 177 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: register offsets, STATUS bit positions and FSM encoding
// shared by the memory-mapped UART transmitter and its FIFO.
package mmio_uart_tx_pkg;

   localparam logic [1:0] UART_REG_TXDATA  = 2'd0;
   localparam logic [1:0] UART_REG_STATUS  = 2'd1;
   localparam logic [1:0] UART_REG_DIVISOR = 2'd2;

   localparam int UART_STAT_FULL  = 0;
   localparam int UART_STAT_EMPTY = 1;
   localparam int UART_STAT_BUSY  = 2;
   localparam int UART_STAT_OVF   = 3;

   typedef enum logic [1:0] {
      UART_ST_IDLE  = 2'd0,
      UART_ST_START = 2'd1,
      UART_ST_DATA  = 2'd2,
      UART_ST_STOP  = 2'd3
   } uart_state_e;

   // A programmed divisor of 0 behaves as 1 clock per bit.
   function automatic logic [15:0] uart_eff_div(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

endpackage

// File: rtl/mmio_sync_fifo.sv
// mmio_sync_fifo: synchronous FIFO, power-of-two DEPTH, sync active-low reset.
// Ports: push_i/wdata_i write, pop_i/rdata_o read (show-ahead), full/empty/count.
module mmio_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: bus-mapped 8N1 UART transmitter with TX FIFO and divisor.
// Ports: clk/rst_n, addr/wdata/wenable bus in, rdata/sel out, tx pin, irq_empty.
module mmio_uart_tx
   import mmio_uart_tx_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wenable,
   output logic [31:0] rdata,
   output logic        sel,
   output logic        tx,
   output logic        irq_empty
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]    reg_off;
   logic          push_req, fifo_push, fifo_pop;
   logic          fifo_full, fifo_empty;
   logic [7:0]    fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic          ovf_clr, div_wr_lo, div_wr_hi, busy;
   logic          ovf_q, ovf_d;
   logic [15:0]   div_q, div_d, div_m1;
   uart_state_e   state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          irq_q, irq_d;
   logic          unused_bits;

   assign reg_off   = addr[3:2];
   assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
   assign push_req  = sel && (reg_off == UART_REG_TXDATA) && wenable[0];
   assign fifo_push = push_req && !fifo_full;
   assign ovf_clr   = sel && (reg_off == UART_REG_STATUS) && wenable[0]
                      && wdata[UART_STAT_OVF];
   assign div_wr_lo = sel && (reg_off == UART_REG_DIVISOR) && wenable[0];
   assign div_wr_hi = sel && (reg_off == UART_REG_DIVISOR) && wenable[1];
   assign div_m1    = uart_eff_div(div_q) - 16'd1;
   assign busy      = (state_q != UART_ST_IDLE);
   assign unused_bits = ^{addr[1:0], wdata[31:16], fifo_count};

   mmio_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .wdata_i (wdata[7:0]),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      rdata = '0;
      if (sel) begin
         unique case (reg_off)
            UART_REG_STATUS: begin
               rdata[UART_STAT_FULL]  = fifo_full;
               rdata[UART_STAT_EMPTY] = fifo_empty;
               rdata[UART_STAT_BUSY]  = busy;
               rdata[UART_STAT_OVF]   = ovf_q;
            end
            UART_REG_DIVISOR: rdata[15:0] = div_q;
            default: rdata = '0;
         endcase
      end
   end

   // Fullness is judged pre-edge, so a same-cycle pop never rescues a push.
   always_comb begin
      ovf_d = ovf_q;
      if (push_req && fifo_full) ovf_d = 1'b1;
      else if (ovf_clr)          ovf_d = 1'b0;
      div_d = div_q;
      if (div_wr_lo) div_d[7:0]  = wdata[7:0];
      if (div_wr_hi) div_d[15:8] = wdata[15:8];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      fifo_pop = 1'b0;
      unique case (state_q)
         UART_ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shift_d  = fifo_rdata;
               cnt_d    = div_m1;
               state_d  = UART_ST_START;
            end
         end
         UART_ST_START: begin
            if (cnt_q == 16'd0) begin
               cnt_d   = div_m1;
               bit_d   = 3'd0;
               state_d = UART_ST_DATA;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         UART_ST_DATA: begin
            if (cnt_q == 16'd0) begin
               cnt_d   = div_m1;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = UART_ST_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         UART_ST_STOP: begin
            if (cnt_q == 16'd0) begin
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shift_d  = fifo_rdata;
                  cnt_d    = div_m1;
                  state_d  = UART_ST_START;
               end else begin
                  state_d = UART_ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = UART_ST_IDLE;
      endcase
      // tx and irq are registered from next-state values so they line up
      // with the state they describe.
      unique case (state_d)
         UART_ST_START: tx_d = 1'b0;
         UART_ST_DATA:  tx_d = shift_d[0];
         default:       tx_d = 1'b1;
      endcase
      // Reaching IDLE implies the FIFO was empty pre-edge.
      irq_d = (state_d == UART_ST_IDLE) && !fifo_push;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= UART_ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         irq_q   <= 1'b1;
         ovf_q   <= 1'b0;
         div_q   <= DEFAULT_DIV;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         irq_q   <= irq_d;
         ovf_q   <= ovf_d;
         div_q   <= div_d;
      end
   end

   assign tx        = tx_q;
   assign irq_empty = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: register table, directed frame/overflow/reset sequences
// and randomized byte streams checked against a frame-timing model.
module tb_mmio_uart_tx;

   localparam logic [31:0] A_TX  = 32'h1000_0000;
   localparam logic [31:0] A_ST  = 32'h1000_0004;
   localparam logic [31:0] A_DV  = 32'h1000_0008;
   localparam logic [31:0] A_RS  = 32'h1000_000C;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  wenable;
   logic        sel, tx, irq_empty;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int mon_div = 434;

   logic [7:0] rxq [$];
   int         stq [$];
   logic [7:0] exp_b [$];
   int         exp_p [$];
   int         exp_s [$];

   typedef struct {
      logic [31:0] a;
      logic [3:0]  we;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_sel;
   } vec_t;

   vec_t tbl [14];

   mmio_uart_tx #(
      .BASE_ADDR   (32'h1000_0000),
      .FIFO_DEPTH  (8),
      .DEFAULT_DIV (16'd434)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .addr      (addr),
      .wdata     (wdata),
      .wenable   (wenable),
      .rdata     (rdata),
      .sel       (sel),
      .tx        (tx),
      .irq_empty (irq_empty)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Frame decoder: start bit div cycles low, 8 bits of div cycles, stop high.
   always begin : monitor
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin : frame
         int s;
         int d;
         logic [7:0] b;
         bit bad;
         bit abort;
         s = cyc;
         d = mon_div;
         b = '0;
         bad = 1'b0;
         abort = 1'b0;
         for (int k = 0; k < 10 * d; k++) begin
            if (k > 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
               abort = 1'b1;
               break;
            end
            if (k < d) begin
               if (tx !== 1'b0) bad = 1'b1;
            end else if (k < 9 * d) begin
               int j;
               j = k / d - 1;
               if (k % d == 0) b[j] = tx;
               else if (tx !== b[j]) bad = 1'b1;
            end else begin
               if (tx !== 1'b1) bad = 1'b1;
            end
         end
         if (!abort) begin
            checks++;
            if (bad) begin
               errors++;
               $display("FAIL frame_shape: start %0d got byte %02h, required clean 8N1 frame",
                        s, b);
            end
            rxq.push_back(b);
            stq.push_back(s);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] we, output int t);
      addr = a;
      wdata = d;
      wenable = we;
      @(posedge clk);
      #1 t = cyc;
      @(negedge clk);
      wenable = 4'b0000;
   endtask

   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d,
                         output logic s);
      addr = a;
      wenable = 4'b0000;
      #1;
      d = rdata;
      s = sel;
   endtask

   task automatic rd_chk(input string nm, input logic [31:0] a,
                         input logic [31:0] exp);
      logic [31:0] d;
      logic s;
      bus_rd(a, d, s);
      chk(nm, d, exp);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic set_div(input logic [15:0] d);
      int t;
      bus_wr(A_DV, {16'h0, d}, 4'b0011, t);
      mon_div = (d == 16'd0) ? 1 : int'(d);
   endtask

   task automatic push(input logic [7:0] b, input bit accepted);
      int t;
      bus_wr(A_TX, {24'h0, b}, 4'b0001, t);
      if (accepted) begin
         exp_b.push_back(b);
         exp_p.push_back(t);
      end
   endtask

   // A byte's frame starts one cycle after its push or right after the
   // previous frame's 10*div cycles, whichever is later.
   task automatic model_starts(input int d);
      exp_s.delete();
      for (int i = 0; i < exp_p.size(); i++) begin
         int s;
         s = exp_p[i] + 1;
         if (i > 0 && exp_s[i-1] + 10 * d > s) s = exp_s[i-1] + 10 * d;
         exp_s.push_back(s);
      end
   endtask

   function automatic int model_end(input int d);
      return exp_s[exp_s.size()-1] + 10 * d;
   endfunction

   task automatic check_frames(input string nm);
      chk({nm, "_count"}, rxq.size(), exp_b.size());
      for (int i = 0; i < exp_b.size() && i < rxq.size(); i++) begin
         chk($sformatf("%s_byte%0d", nm, i), {24'h0, rxq[i]}, {24'h0, exp_b[i]});
         chk($sformatf("%s_start%0d", nm, i), stq[i], exp_s[i]);
      end
      rxq.delete();
      stq.delete();
      exp_b.delete();
      exp_p.delete();
      exp_s.delete();
   endtask

   initial begin
      logic [31:0] rd;
      logic        sl;
      int          t, e, lows;

      rst_n = 1'b0;
      addr = '0;
      wdata = '0;
      wenable = 4'b0000;

      tbl[0]  = '{A_ST, 4'b0000, 32'h0,          32'h2,    1'b1};
      tbl[1]  = '{A_DV, 4'b0000, 32'h0,          32'd434,  1'b1};
      tbl[2]  = '{A_TX, 4'b0000, 32'h0,          32'h0,    1'b1};
      tbl[3]  = '{A_RS, 4'b0000, 32'h0,          32'h0,    1'b1};
      tbl[4]  = '{A_DV, 4'b0001, 32'hFFFF_FF07,  32'h0107, 1'b1};
      tbl[5]  = '{A_DV, 4'b0010, 32'h0000_0300,  32'h0307, 1'b1};
      tbl[6]  = '{A_DV, 4'b1100, 32'hFFFF_FFFF,  32'h0307, 1'b1};
      tbl[7]  = '{32'h1000_000A, 4'b0011, 32'h4, 32'h4,    1'b1};
      tbl[8]  = '{A_RS, 4'b1111, 32'hFFFF_FFFF,  32'h0,    1'b1};
      tbl[9]  = '{32'h2000_0008, 4'b1111, 32'h55, 32'h0,   1'b0};
      tbl[10] = '{32'h2000_0000, 4'b0001, 32'h5A, 32'h0,   1'b0};
      tbl[11] = '{A_ST, 4'b1111, 32'hFFFF_FFFF,  32'h2,    1'b1};
      tbl[12] = '{A_DV, 4'b0000, 32'h0,          32'h4,    1'b1};
      tbl[13] = '{32'h1000_0010, 4'b0000, 32'h0, 32'h0,    1'b0};

      repeat (2) @(negedge clk);
      chk("reset_tx", {31'h0, tx}, 32'h1);
      chk("reset_irq", {31'h0, irq_empty}, 32'h1);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         if (tbl[i].we != 4'b0000) bus_wr(tbl[i].a, tbl[i].wd, tbl[i].we, t);
         bus_rd(tbl[i].a, rd, sl);
         chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
         chk($sformatf("vec%0d_sel", i), {31'h0, sl}, {31'h0, tbl[i].exp_sel});
      end
      repeat (5) @(negedge clk);
      chk("no_stray_frames", rxq.size(), 0);
      chk("idle_tx", {31'h0, tx}, 32'h1);

      // Single 0xA5 frame at div 4.
      set_div(16'd4);
      push(8'hA5, 1'b1);
      model_starts(4);
      e = model_end(4);
      wait_cyc(exp_s[0] + 5);
      rd_chk("a5_status_busy", A_ST, 32'h6);
      wait_cyc(e - 1);
      chk("a5_irq_stop", {31'h0, irq_empty}, 32'h0);
      wait_cyc(e);
      chk("a5_irq_done", {31'h0, irq_empty}, 32'h1);
      rd_chk("a5_status_done", A_ST, 32'h2);
      wait_cyc(e + 2);
      check_frames("a5");

      // Three back-to-back bytes at div 2.
      set_div(16'd2);
      push(8'h11, 1'b1);
      push(8'hC3, 1'b1);
      push(8'h80, 1'b1);
      model_starts(2);
      e = model_end(2);
      wait_cyc(exp_s[1] + 3);
      chk("b2b_irq_mid", {31'h0, irq_empty}, 32'h0);
      wait_cyc(e - 1);
      chk("b2b_irq_stop", {31'h0, irq_empty}, 32'h1 ^ 32'h1);
      wait_cyc(e);
      chk("b2b_irq_done", {31'h0, irq_empty}, 32'h1);
      wait_cyc(e + 2);
      check_frames("b2b");

      // Overflow: one byte in the shifter, eight fill the FIFO, ninth drops.
      push(8'h01, 1'b1);
      wait_cyc(cyc + 3);
      for (int i = 0; i < 8; i++) push(8'h20 + 8'(i), 1'b1);
      push(8'hEE, 1'b0);
      rd_chk("ovf_status_set", A_ST, 32'hD);
      bus_wr(A_ST, 32'h8, 4'b0001, t);
      rd_chk("ovf_status_clr", A_ST, 32'h5);
      model_starts(2);
      e = model_end(2);
      wait_cyc(e + 2);
      check_frames("ovf");
      rd_chk("ovf_status_end", A_ST, 32'h2);

      // Reset in the middle of a data bit with bytes still queued.
      set_div(16'd3);
      push(8'h96, 1'b1);
      push(8'h69, 1'b1);
      push(8'hF0, 1'b1);
      model_starts(3);
      wait_cyc(exp_s[0] + 13);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_tx_high", {31'h0, tx}, 32'h1);
      chk("rst_irq", {31'h0, irq_empty}, 32'h1);
      rst_n = 1'b1;
      mon_div = 434;
      rd_chk("rst_status", A_ST, 32'h2);
      rd_chk("rst_div", A_DV, 32'd434);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      chk("rst_tx_quiet", lows, 0);
      chk("rst_no_frames", rxq.size(), 0);
      exp_b.delete();
      exp_p.delete();
      exp_s.delete();

      // Divisor 0 acts as 1: ten-cycle frame.
      set_div(16'd0);
      rd_chk("div0_read", A_DV, 32'h0);
      push(8'h3C, 1'b1);
      model_starts(1);
      wait_cyc(model_end(1) + 2);
      check_frames("div0");

      // Randomized streams with random gaps and divisors.
      for (int it = 0; it < 6; it++) begin
         int d, deff, n;
         d = $urandom_range(0, 5);
         deff = (d == 0) ? 1 : d;
         set_div(16'(d));
         n = $urandom_range(1, 8);
         for (int j = 0; j < n; j++) begin
            push(8'($urandom), 1'b1);
            repeat ($urandom_range(0, 12)) @(negedge clk);
         end
         model_starts(deff);
         wait_cyc(model_end(deff) + 2);
         check_frames($sformatf("rnd%0d", it));
         rd_chk($sformatf("rnd%0d_status", it), A_ST, 32'h2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
